// File: rtl/blit_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module   : blit_cmd_queue
// Purpose  : Packs four 32-bit CPU words into 128-bit blit commands and
//            buffers them in a DEPTH-entry FIFO for blit_command.
//            Optional privileged-opcode squashing: BLIT_PRIV_CHECK_EN.
// Revision : 1.0  initial release
// ============================================================================
module blit_cmd_queue #(
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cpu_write,
    input  logic [31:0]              cpu_wdata,
    input  logic                     cpu_supervisor,
    input  logic                     cpu_resync,
    input  logic                     cpu_clear_err,
    output logic [127:0]             cmd,
    output logic                     cmd_valid,
    input  logic                     next_cmd,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     priv_error
);

    localparam int                 c_PTR_W   = $clog2(DEPTH);
    localparam int                 c_LVL_W   = c_PTR_W + 1;
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [c_LVL_W-1:0] c_LVL_ONE = c_LVL_W'(1);
    localparam logic [c_LVL_W-1:0] c_FULL    = c_LVL_W'(DEPTH);

    logic [1:0]          r_wcnt;
    logic [31:0]         r_slot0;
    logic [31:0]         r_slot1;
    logic [31:0]         r_slot2;
    logic [127:0]        r_mem [DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_LVL_W-1:0]  r_level;
    logic                r_overflow;

    logic                w_wr;
    logic                w_push_req;
    logic                w_pop;
    logic                w_full;
    logic                w_push;
    logic                w_drop;
    logic [7:0]          w_opcode;
    logic [127:0]        w_entry;

    // Resync wins over a same-cycle write, so the word never reaches a slot.
    assign w_wr       = cpu_write && !cpu_resync;
    assign w_push_req = w_wr && (r_wcnt == 2'd3);
    assign w_pop      = next_cmd && (r_level != '0);
    assign w_full     = (r_level == c_FULL);
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;

    // Word 3 goes straight into the FIFO without touching the staging slots.
    assign w_entry = {cpu_wdata, r_slot2, r_slot1, r_slot0[31:8], w_opcode};

`ifdef BLIT_PRIV_CHECK_EN
    logic r_user_seen;
    logic r_priv_error;
    logic w_priv_viol;

    assign w_priv_viol = w_push_req && r_slot0[7] && (r_user_seen || !cpu_supervisor);
    assign w_opcode    = w_priv_viol ? 8'h00 : r_slot0[7:0];
    assign priv_error  = r_priv_error;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_user_seen  <= 1'b0;
            r_priv_error <= 1'b0;
        end else begin
            if (cpu_resync || w_push_req) begin
                r_user_seen <= 1'b0;
            end else if (w_wr && !cpu_supervisor) begin
                r_user_seen <= 1'b1;
            end

            if (w_priv_viol) begin
                r_priv_error <= 1'b1;
            end else if (cpu_clear_err) begin
                r_priv_error <= 1'b0;
            end
        end
    end
`else
    logic w_unused_supervisor;

    assign w_unused_supervisor = cpu_supervisor;
    assign w_opcode            = r_slot0[7:0];
    assign priv_error          = 1'b0;
`endif

    // Control state
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wcnt     <= 2'd0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (cpu_resync) begin
                r_wcnt <= 2'd0;
            end else if (cpu_write) begin
                r_wcnt <= r_wcnt + 2'd1;
            end

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end

            if (w_push && !w_pop) begin
                r_level <= r_level + c_LVL_ONE;
            end else if (w_pop && !w_push) begin
                r_level <= r_level - c_LVL_ONE;
            end

            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (cpu_clear_err) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Datapath storage is deliberately left out of reset.
    always_ff @(posedge clock) begin
        if (w_wr) begin
            case (r_wcnt)
                2'd0:    r_slot0 <= cpu_wdata;
                2'd1:    r_slot1 <= cpu_wdata;
                2'd2:    r_slot2 <= cpu_wdata;
                default: ;
            endcase
        end
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    assign cmd       = r_mem[r_rd_ptr];
    assign cmd_valid = (r_level != '0);
    assign level     = r_level;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_blit_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_blit_cmd_queue
// Purpose  : Directed plus random checking of blit_cmd_queue against a
//            queue-based reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_blit_cmd_queue;

    localparam int DEPTH = 16;

    logic                    clock = 1'b0;
    logic                    reset = 1'b1;
    logic                    cpu_write = 1'b0;
    logic [31:0]             cpu_wdata = '0;
    logic                    cpu_supervisor = 1'b1;
    logic                    cpu_resync = 1'b0;
    logic                    cpu_clear_err = 1'b0;
    logic [127:0]            cmd;
    logic                    cmd_valid;
    logic                    next_cmd = 1'b0;
    logic [$clog2(DEPTH):0]  level;
    logic                    overflow;
    logic                    priv_error;

    blit_cmd_queue #(.DEPTH(DEPTH)) dut (
        .clock          (clock),
        .reset          (reset),
        .cpu_write      (cpu_write),
        .cpu_wdata      (cpu_wdata),
        .cpu_supervisor (cpu_supervisor),
        .cpu_resync     (cpu_resync),
        .cpu_clear_err  (cpu_clear_err),
        .cmd            (cmd),
        .cmd_valid      (cmd_valid),
        .next_cmd       (next_cmd),
        .level          (level),
        .overflow       (overflow),
        .priv_error     (priv_error)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Reference model: partially gathered words, command queue, sticky flags.
    logic [31:0]  m_words[$];
    bit           m_user;
    logic [127:0] m_q[$];
    bit           m_ovf;
    bit           m_priv;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("level", 128'(level), 128'(m_q.size()));
        chk("cmd_valid", 128'(cmd_valid), 128'(m_q.size() != 0));
        chk("overflow", 128'(overflow), 128'(m_ovf));
        chk("priv_error", 128'(priv_error), 128'(m_priv));
        if (m_q.size() != 0) chk("cmd", cmd, m_q[0]);
    endtask

    task automatic step(input bit wr, input logic [31:0] d, input bit sup,
                        input bit rs, input bit clr, input bit pop);
        bit           m_pop;
        bit           set_ovf;
        bit           set_priv;
        bit           any_user;
        logic [127:0] entry;
        cpu_write      = wr;
        cpu_wdata      = d;
        cpu_supervisor = sup;
        cpu_resync     = rs;
        cpu_clear_err  = clr;
        next_cmd       = pop;
        m_pop    = pop && (m_q.size() != 0);
        set_ovf  = 1'b0;
        set_priv = 1'b0;
        if (m_pop) void'(m_q.pop_front());
        if (rs) begin
            m_words.delete();
            m_user = 1'b0;
        end else if (wr) begin
            any_user = m_user || !sup;
            if (m_words.size() == 3) begin
                entry = {d, m_words[2], m_words[1], m_words[0]};
`ifdef BLIT_PRIV_CHECK_EN
                if (entry[7] && any_user) begin
                    entry[7:0] = 8'h00;
                    set_priv = 1'b1;
                end
`endif
                // Queue size here is already post-pop, so full-with-pop accepts.
                if (m_q.size() == DEPTH) set_ovf = 1'b1;
                else m_q.push_back(entry);
                m_words.delete();
                m_user = 1'b0;
            end else begin
                m_words.push_back(d);
                m_user = any_user;
            end
        end
        m_ovf  = set_ovf  || (m_ovf  && !clr);
        m_priv = set_priv || (m_priv && !clr);
        @(posedge clock);
        #1;
        cpu_write = 1'b0; cpu_resync = 1'b0; cpu_clear_err = 1'b0; next_cmd = 1'b0;
        check_model();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        m_words.delete();
        m_q.delete();
        m_user = 1'b0;
        m_ovf  = 1'b0;
        m_priv = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check_model();
    endtask

    task automatic wr_word(input logic [31:0] d, input bit sup);
        step(1'b1, d, sup, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wr_cmd(input logic [31:0] a0, input bit sup, input bit pop_last);
        wr_word(a0, sup);
        wr_word($urandom, sup);
        wr_word($urandom, sup);
        step(1'b1, $urandom, sup, 1'b0, 1'b0, pop_last);
    endtask

    initial begin
        logic [127:0] head;
        #1;
        do_reset();
        chk("reset_level", 128'(level), 128'd0);
        chk("reset_valid", 128'(cmd_valid), 128'd0);
        chk("reset_overflow", 128'(overflow), 128'd0);
        chk("reset_priv", 128'(priv_error), 128'd0);

        // Basic push
        wr_word(32'h00000001, 1'b1);
        wr_word(32'h00100010, 1'b1);
        wr_word(32'h00200020, 1'b1);
        chk("not_yet_valid", 128'(cmd_valid), 128'd0);
        wr_word(32'h0000000F, 1'b1);
        chk("basic_cmd", cmd, 128'h0000000F_00200020_00100010_00000001);
        chk("basic_level", 128'(level), 128'd1);

        // Pop, then pop while empty
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("pop_valid", 128'(cmd_valid), 128'd0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("empty_pop_level", 128'(level), 128'd0);

        // Fill, overflow, then full with simultaneous pop
        for (int i = 0; i < DEPTH; i++) wr_cmd($urandom & 32'hFFFF_FF7F, 1'b1, 1'b0);
        chk("full_level", 128'(level), 128'(DEPTH));
        head = m_q[0];
        wr_cmd(32'h0000_0042, 1'b1, 1'b0);
        chk("ovf_set", 128'(overflow), 128'd1);
        chk("ovf_level", 128'(level), 128'(DEPTH));
        chk("ovf_head", cmd, head);
        step(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("ovf_cleared", 128'(overflow), 128'd0);
        wr_cmd(32'h0000_0043, 1'b1, 1'b1);
        chk("full_pop_level", 128'(level), 128'(DEPTH));
        chk("full_pop_noovf", 128'(overflow), 128'd0);
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("drained", 128'(level), 128'd0);

        // Privilege check
        wr_cmd(32'h0000_0081, 1'b0, 1'b0);
`ifdef BLIT_PRIV_CHECK_EN
        chk("priv_user_op", 128'(cmd[7:0]), 128'h00);
        chk("priv_user_flag", 128'(priv_error), 128'd1);
`else
        chk("priv_user_op", 128'(cmd[7:0]), 128'h81);
        chk("priv_user_flag", 128'(priv_error), 128'd0);
`endif
        step(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("priv_cleared", 128'(priv_error), 128'd0);
        wr_cmd(32'h0000_0081, 1'b1, 1'b0);
        chk("priv_super_op", 128'(cmd[7:0]), 128'h81);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);

        // Resync discards a partial command
        wr_word(32'hDEAD_0001, 1'b1);
        wr_word(32'hDEAD_0002, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
        wr_word(32'h1111_1111, 1'b1);
        wr_word(32'h2222_2222, 1'b1);
        wr_word(32'h3333_3333, 1'b1);
        wr_word(32'h4444_4444, 1'b1);
        chk("resync_level", 128'(level), 128'd1);
        chk("resync_cmd", cmd, 128'h44444444_33333333_22222222_11111111);

        // Reset in the middle of assembly
        for (int i = 0; i < 4; i++) wr_cmd($urandom, 1'b1, 1'b0);
        chk("pre_reset_level", 128'(level), 128'd5);
        wr_word(32'hAAAA_0001, 1'b1);
        wr_word(32'hAAAA_0002, 1'b1);
        wr_word(32'hAAAA_0003, 1'b1);
        do_reset();
        chk("mid_reset_level", 128'(level), 128'd0);
        chk("mid_reset_valid", 128'(cmd_valid), 128'd0);
        wr_word(32'h0000_0005, 1'b1);
        wr_word(32'h0000_0006, 1'b1);
        wr_word(32'h0000_0007, 1'b1);
        wr_word(32'h0000_0008, 1'b1);
        chk("post_reset_cmd", cmd, 128'h00000008_00000007_00000006_00000005);

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) < 6,
                 $urandom,
                 $urandom_range(0, 9) < 7,
                 $urandom_range(0, 99) < 3,
                 $urandom_range(0, 99) < 5,
                 $urandom_range(0, 9) < 3);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/blit_cmd_queue.md
# blit_cmd_queue

Command queue feeding `blit_command`. Gathers four consecutive 32-bit CPU writes into one 128-bit blit command and buffers up to `DEPTH` commands in a FIFO. Presents the head entry on the `cmd`/`cmd_valid`/`next_cmd` interface. Can force privileged opcodes (bit 7 set) issued from user mode to NOP and flag the violation.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, minimum 2.
- `clock`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cpu_write`  in  1  one-cycle strobe; `cpu_wdata` is the next command word.
- `cpu_wdata`  in  32  command word. Word order is arg0, arg1, arg2, arg3; arg0[7:0] is the opcode.
- `cpu_supervisor`  in  1  privilege of the current write; sampled on every word.
- `cpu_resync`  in  1  discards the partially assembled command; word counter returns to 0.
- `cpu_clear_err`  in  1  clears `overflow` and `priv_error`.
- `cmd`  out  128  head entry `{arg3,arg2,arg1,arg0}`.
- `cmd_valid`  out  1  FIFO non-empty.
- `next_cmd`  in  1  one-cycle pop pulse from `blit_command`.
- `level`  out  $clog2(DEPTH)+1  number of stored commands.
- `overflow`  out  1  sticky: a complete command was dropped because the FIFO was full.
- `priv_error`  out  1  sticky: a privileged opcode was written in user mode.

## Operation
- **Word assembly**
  - A 2-bit `wcnt` selects the word slot.
  - Each `cpu_write` stores `cpu_wdata` into staging slot `wcnt`, then increments `wcnt`, wrapping 3→0.
  - A `user_seen` flag is set when any word of the current command is written with `cpu_supervisor=0`. It clears when `wcnt` wraps.
- **Push**
  - Occurs on the write with `wcnt==3`.
  - The pushed entry is `{cpu_wdata, slot2, slot1, slot0}`; word 3 bypasses the staging register.
- **Privilege check** (under the configuration macro)
  - Applies when opcode bit 7 = 1 and (`user_seen` or the current `cpu_supervisor=0`).
  - The pushed arg0[7:0] is forced to 8'h00 (NOP). All other bits are unchanged.
  - `priv_error` is set.
- **FIFO**
  - Register array with `wr_ptr`/`rd_ptr` of width $clog2(DEPTH), plus a count.
  - `cmd = mem[rd_ptr]`, driven combinationally from registers. `cmd_valid = (level != 0)`.
  - **Pop:** when `next_cmd=1` and `level != 0`, `rd_ptr` increments. `next_cmd` while empty is ignored.
  - **Full:** a push with `level==DEPTH` and no pop in the same cycle is dropped. `overflow` is set. `wcnt` still wraps to 0.
  - **Simultaneous push and pop:**
    - With `level==DEPTH`, the push is accepted and `level` is unchanged.
    - With `level==0`, only the push takes effect; the pop is ignored because the queue is empty.
  - Pointers wrap modulo `DEPTH`.
- **Resync and error clear**
  - `cpu_resync` has priority over a same-cycle `cpu_write`: the word is discarded, and `wcnt` and `user_seen` clear.
  - `cpu_resync` does not affect the FIFO.
  - `cpu_clear_err` has priority below a same-cycle set: a set and a clear in the same cycle leave the flag set.
- **Reset**
  - Applies mid-operation too. Clears `wcnt`, `user_seen`, pointers, `level`, `overflow`, `priv_error`.
  - Entry contents are not cleared.
  - Output reset values: `cmd_valid=0`, `level=0`, `overflow=0`, `priv_error=0`. `cmd` is don't-care while `cmd_valid=0`.

## Timing
- **Push latency:** the 4th word's `cpu_write` is sampled at edge N. `cmd_valid` is high and `cmd` is valid after edge N (visible in cycle N+1) if the FIFO was empty.
- **Pop:** `next_cmd` is sampled at edge N. From cycle N+1, `cmd` shows the next entry, or `cmd_valid` is low.
  - `blit_command` spends one WAIT cycle after pulsing `next_cmd`, so it never sees a stale head.
- **Back-to-back:** one word per cycle sustained; one command completed every 4 cycles.
- **Full status:** `level` and the sticky flags update on the same edge as the causing event.

## Configuration
- **`BLIT_PRIV_CHECK_EN` defined:** the privilege check is active, as described above.
- **Not defined:**
  - Opcodes pass unmodified.
  - `user_seen` logic is removed.
  - `priv_error` is tied to 0.
  - `cpu_supervisor` is unused.

## Test plan
- **Basic push:** after reset, write 0x00000001, 0x00100010, 0x00200020, 0x0000000F (supervisor) → cycle after 4th write: `cmd_valid=1`, `cmd=128'h0000000F_00200020_00100010_00000001`, `level=1`.
- **Pop:** pulse `next_cmd` once → next cycle `cmd_valid=0`, `level=0`. A further `next_cmd` while empty leaves `level=0`.
- **Full:**
  - Fill 16 commands with no pop → `level=16`. A 17th command is dropped: `overflow=1`, `level=16`, head unchanged.
  - Repeat with `next_cmd` asserted on the 4th-word cycle → accepted, `level` stays 16, no overflow.
- **Privilege:**
  - User-mode command with arg0=0x00000081 → queued arg0[7:0]=0x00, `priv_error=1`.
  - Same command with supervisor on all words → 0x81 passes.
  - `cpu_clear_err` → `priv_error=0`.
- **Resync:** write 2 words, pulse `cpu_resync`, then write 4 fresh words → exactly one entry, equal to the fresh words.
- **Reset mid-assembly:** write 3 words with `level=5`, assert `reset` → `level=0`, `cmd_valid=0`. The next 4 words form one correctly aligned command.
